// File: rtl/regfile_sb.sv
// Two-read / two-write integer register file with per-register busy scoreboard.
// Register 0 is hardwired to zero and is never marked busy.
module regfile_sb #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  localparam int unsigned AW    = $clog2(NREG),
  parameter int unsigned BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            wen1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic [AW-1:0]   raddr0,
  output logic [XLEN-1:0] rdata0,
  output logic            rbusy0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  output logic            rbusy1,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic [AW:0]     busy_cnt
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_d;

  logic [AW-1:0]   raddr_s [2];
  logic [XLEN-1:0] rdata_s [2];
  logic            rbusy_s [2];

  // Busy bit next state: issue beats writeback so a newer producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < int'(NREG); i++) begin
      if (iss_valid && (iss_rd == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((wen0 && (waddr0 == AW'(i))) || (wen1 && (waddr1 == AW'(i)))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    busy_d[0] = 1'b0;
  end

  // Counter tracks set/clear transitions rather than recounting every cycle.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 1; i < int'(NREG); i++) begin
      if (busy_d[i] && !busy_q[i]) begin
        cnt_d = cnt_d + CNT_ONE;
      end else if (!busy_d[i] && busy_q[i]) begin
        cnt_d = cnt_d - CNT_ONE;
      end else begin
        cnt_d = cnt_d;
      end
    end
  end

  // State registers; port 1 is written last so it wins on a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wen0 && (waddr0 != '0)) begin
        mem_q[waddr0] <= wdata0;
      end
      if (wen1 && (waddr1 != '0)) begin
        mem_q[waddr1] <= wdata1;
      end
      mem_q[0] <= '0;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign raddr_s[0] = raddr0;
  assign raddr_s[1] = raddr1;

  // Read ports: younger write port has forwarding priority; a forwarded hit is never busy.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_s[p] = '0;
      rbusy_s[p] = 1'b0;
      if (raddr_s[p] == '0) begin
        rdata_s[p] = '0;
        rbusy_s[p] = 1'b0;
      end else if ((BYPASS != 0) && wen1 && (waddr1 == raddr_s[p])) begin
        rdata_s[p] = wdata1;
        rbusy_s[p] = 1'b0;
      end else if ((BYPASS != 0) && wen0 && (waddr0 == raddr_s[p])) begin
        rdata_s[p] = wdata0;
        rbusy_s[p] = 1'b0;
      end else begin
        rdata_s[p] = mem_q[raddr_s[p]];
        rbusy_s[p] = busy_q[raddr_s[p]];
      end
    end
  end

  assign rdata0   = rdata_s[0];
  assign rbusy0   = rbusy_s[0];
  assign rdata1   = rdata_s[1];
  assign rbusy1   = rbusy_s[1];
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb, with BYPASS=1 and BYPASS=0 instances
// sharing stimulus and checked against an array-based model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen0, wen1, iss_valid;
  logic [4:0]  waddr0, waddr1, raddr0, raddr1, iss_rd;
  logic [63:0] wdata0, wdata1;

  logic [63:0] b_rdata0, b_rdata1, n_rdata0, n_rdata1;
  logic        b_rbusy0, b_rbusy1, n_rbusy0, n_rbusy1;
  logic [5:0]  b_cnt, n_cnt;

  int checks = 0;
  int passes = 0;

  logic [63:0] m_mem [32];
  bit          m_busy [32];

  regfile_sb #(.XLEN(64), .NREG(32), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .rdata0(b_rdata0), .rbusy0(b_rbusy0),
    .raddr1(raddr1), .rdata1(b_rdata1), .rbusy1(b_rbusy1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(b_cnt)
  );

  regfile_sb #(.XLEN(64), .NREG(32), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr0(raddr0), .rdata0(n_rdata0), .rbusy0(n_rbusy0),
    .raddr1(raddr1), .rdata1(n_rdata1), .rbusy1(n_rbusy1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(n_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", checks, passes);
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 64'd0;
    if (byp && wen1 && waddr1 == a) return wdata1;
    if (byp && wen0 && waddr0 == a) return wdata0;
    return m_mem[a];
  endfunction

  function automatic bit exp_bz(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && ((wen0 && waddr0 == a) || (wen1 && waddr1 == a))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [5:0] exp_cnt();
    int n = 0;
    foreach (m_busy[i]) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  task automatic idle();
    wen0 = 1'b0; wen1 = 1'b0; iss_valid = 1'b0;
    waddr0 = 5'd0; waddr1 = 5'd0; iss_rd = 5'd0;
    wdata0 = 64'd0; wdata1 = 64'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (m_mem[i]) begin m_mem[i] = 64'd0; m_busy[i] = 1'b0; end
    end else begin
      if (wen0 && waddr0 != 5'd0) begin m_mem[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
      if (wen1 && waddr1 != 5'd0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
      if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr0 = 5'(a); raddr1 = 5'(31 - a); #1;
      checks++; if (b_rdata0 !== 64'd0 || b_rbusy0 !== 1'b0) begin $display("FAIL reset_rd0 a=%0d got %h/%b exp 0/0", a, b_rdata0, b_rbusy0); end else passes++;
      checks++; if (n_rdata1 !== 64'd0 || n_rbusy1 !== 1'b0) begin $display("FAIL reset_rd1 a=%0d got %h/%b exp 0/0", 31 - a, n_rdata1, n_rbusy1); end else passes++;
    end
    checks++; if (b_cnt !== 6'd0 || n_cnt !== 6'd0) begin $display("FAIL reset_cnt got %0d/%0d exp 0", b_cnt, n_cnt); end else passes++;
  endtask

  task automatic test_bypass();
    idle(); wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 64'hDEAD_BEEF; raddr0 = 5'd5; #1;
    checks++; if (b_rdata0 !== 64'hDEAD_BEEF) begin $display("FAIL bypass_on got %h exp deadbeef", b_rdata0); end else passes++;
    checks++; if (n_rdata0 !== 64'd0) begin $display("FAIL bypass_off got %h exp 0", n_rdata0); end else passes++;
    tick(); idle(); #1;
    checks++; if (n_rdata0 !== 64'hDEAD_BEEF || b_rdata0 !== 64'hDEAD_BEEF) begin $display("FAIL bypass_next got %h/%h exp deadbeef", b_rdata0, n_rdata0); end else passes++;
  endtask

  task automatic test_same_index();
    idle(); wen0 = 1'b1; wen1 = 1'b1; waddr0 = 5'd7; waddr1 = 5'd7;
    wdata0 = 64'h11; wdata1 = 64'h22; raddr1 = 5'd7; #1;
    checks++; if (b_rdata1 !== 64'h22) begin $display("FAIL dual_bypass got %h exp 22", b_rdata1); end else passes++;
    tick(); idle(); #1;
    checks++; if (b_rdata1 !== 64'h22 || n_rdata1 !== 64'h22) begin $display("FAIL dual_store got %h/%h exp 22", b_rdata1, n_rdata1); end else passes++;
    wen0 = 1'b1; wen1 = 1'b1; waddr0 = 5'd0; waddr1 = 5'd0; wdata0 = 64'h33; wdata1 = 64'h33; raddr0 = 5'd0; #1;
    checks++; if (b_rdata0 !== 64'd0) begin $display("FAIL r0_bypass got %h exp 0", b_rdata0); end else passes++;
    tick(); idle(); #1;
    checks++; if (b_rdata0 !== 64'd0 || n_rdata0 !== 64'd0) begin $display("FAIL r0_store got %h/%h exp 0", b_rdata0, n_rdata0); end else passes++;
  endtask

  task automatic test_busy();
    idle(); iss_valid = 1'b1; iss_rd = 5'd3; tick(); idle(); raddr0 = 5'd3; #1;
    checks++; if (b_rbusy0 !== 1'b1 || n_rbusy0 !== 1'b1 || b_cnt !== 6'd1) begin $display("FAIL issue3 got %b/%b cnt %0d exp 1/1 cnt 1", b_rbusy0, n_rbusy0, b_cnt); end else passes++;
    iss_valid = 1'b1; iss_rd = 5'd3; wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 64'h3; #1;
    checks++; if (b_rbusy0 !== 1'b0 || n_rbusy0 !== 1'b1) begin $display("FAIL wb_hit_busy got %b/%b exp 0/1", b_rbusy0, n_rbusy0); end else passes++;
    tick(); idle(); #1;
    checks++; if (b_rbusy0 !== 1'b1 || b_cnt !== 6'd1) begin $display("FAIL iss_wb_same got %b cnt %0d exp 1 cnt 1", b_rbusy0, b_cnt); end else passes++;
    wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 64'h4; tick(); idle(); #1;
    checks++; if (b_rbusy0 !== 1'b0 || n_cnt !== 6'd0) begin $display("FAIL wb_clear got %b cnt %0d exp 0 cnt 0", b_rbusy0, n_cnt); end else passes++;
  endtask

  task automatic test_swap();
    idle(); iss_valid = 1'b1; iss_rd = 5'd9; tick();
    iss_rd = 5'd4; wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 64'h99; tick(); idle();
    raddr0 = 5'd4; raddr1 = 5'd9; #1;
    checks++; if (b_cnt !== 6'd1 || b_rbusy0 !== 1'b1 || b_rbusy1 !== 1'b0) begin $display("FAIL swap got cnt %0d b4 %b b9 %b exp 1/1/0", b_cnt, b_rbusy0, b_rbusy1); end else passes++;
    iss_valid = 1'b1; iss_rd = 5'd0; tick(); idle(); raddr0 = 5'd0; #1;
    checks++; if (b_cnt !== 6'd1 || b_rbusy0 !== 1'b0) begin $display("FAIL iss_r0 got cnt %0d busy %b exp 1/0", b_cnt, b_rbusy0); end else passes++;
  endtask

  task automatic test_fill_reset();
    idle();
    for (int r = 1; r < 32; r++) begin iss_valid = 1'b1; iss_rd = 5'(r); tick(); end
    idle(); #1;
    checks++; if (b_cnt !== 6'd31 || n_cnt !== 6'd31) begin $display("FAIL fill got %0d/%0d exp 31", b_cnt, n_cnt); end else passes++;
    rst = 1'b1; wen0 = 1'b1; waddr0 = 5'd10; wdata0 = 64'hAAAA; wen1 = 1'b1; waddr1 = 5'd11; wdata1 = 64'hBBBB;
    iss_valid = 1'b1; iss_rd = 5'd12; tick(); rst = 1'b0; idle();
    for (int a = 0; a < 32; a++) begin
      raddr0 = 5'(a); #1;
      checks++; if (n_rdata0 !== 64'd0 || n_rbusy0 !== 1'b0) begin $display("FAIL mid_rst a=%0d got %h/%b exp 0/0", a, n_rdata0, n_rbusy0); end else passes++;
    end
    checks++; if (b_cnt !== 6'd0) begin $display("FAIL mid_rst_cnt got %0d exp 0", b_cnt); end else passes++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      wen0 = $urandom_range(0, 1) == 1; waddr0 = 5'($urandom); wdata0 = {$urandom, $urandom};
      wen1 = $urandom_range(0, 2) == 0; waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom); wdata1 = {$urandom, $urandom};
      iss_valid = $urandom_range(0, 1) == 1; iss_rd = 5'($urandom);
      raddr0 = ($urandom_range(0, 2) == 0) ? waddr0 : 5'($urandom);
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr1 : 5'($urandom); #1;
      checks++; if (b_rdata0 !== exp_rd(raddr0, 1'b1) || b_rbusy0 !== exp_bz(raddr0, 1'b1)) begin $display("FAIL rnd_b0 c=%0d a=%0d got %h/%b exp %h/%b", c, raddr0, b_rdata0, b_rbusy0, exp_rd(raddr0, 1'b1), exp_bz(raddr0, 1'b1)); end else passes++;
      checks++; if (b_rdata1 !== exp_rd(raddr1, 1'b1) || b_rbusy1 !== exp_bz(raddr1, 1'b1)) begin $display("FAIL rnd_b1 c=%0d a=%0d got %h/%b exp %h/%b", c, raddr1, b_rdata1, b_rbusy1, exp_rd(raddr1, 1'b1), exp_bz(raddr1, 1'b1)); end else passes++;
      checks++; if (n_rdata0 !== exp_rd(raddr0, 1'b0) || n_rbusy1 !== exp_bz(raddr1, 1'b0)) begin $display("FAIL rnd_n c=%0d got %h/%b exp %h/%b", c, n_rdata0, n_rbusy1, exp_rd(raddr0, 1'b0), exp_bz(raddr1, 1'b0)); end else passes++;
      checks++; if (b_cnt !== exp_cnt() || n_cnt !== exp_cnt()) begin $display("FAIL rnd_cnt c=%0d got %0d/%0d exp %0d", c, b_cnt, n_cnt, exp_cnt()); end else passes++;
      tick();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    idle(); rst = 1'b1; raddr0 = 5'd0; raddr1 = 5'd0;
    foreach (m_mem[i]) begin m_mem[i] = 64'd0; m_busy[i] = 1'b0; end
    #3;
    test_reset();
    test_bypass();
    test_same_index();
    test_busy();
    test_swap();
    test_fill_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated busy-bit scoreboard, for the pipelined core. It has two combinational read ports and two synchronous write ports, with an optional write-to-read bypass. A per-register busy bit is set when an instruction naming that register as destination issues, and cleared when that register is written back. Decode reads operands and busy flags from this block to decide whether to stall.

## Interface
Parameters:
- XLEN, 64, register width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREG), index width; derived, never overridden.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see pre-edge contents.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- wen0  in  1  write port 0 enable (older writeback).
- waddr0  in  AW  write port 0 index.
- wdata0  in  XLEN  write port 0 data.
- wen1  in  1  write port 1 enable (younger writeback).
- waddr1  in  AW  write port 1 index.
- wdata1  in  XLEN  write port 1 data.
- raddr0  in  AW  read port 0 index.
- rdata0  out  XLEN  read port 0 data.
- rbusy0  out  1  register raddr0 has a pending write.
- raddr1  in  AW  read port 1 index.
- rdata1  out  XLEN  read port 1 data.
- rbusy1  out  1  register raddr1 has a pending write.
- iss_valid  in  1  an instruction with destination iss_rd issues this cycle.
- iss_rd  in  AW  destination index of the issuing instruction.
- busy_cnt  out  AW+1  number of registers currently marked busy.

## Operation
- State: NREG-1 data registers of XLEN bits, plus NREG-1 busy bits.
- Register 0:
  - Reads always return 0 and rbusy 0.
  - Writes to register 0 are discarded.
  - iss_rd = 0 never sets a busy bit.
- Write: wenK=1 and waddrK≠0 loads wdataK into waddrK at the edge.
  - If both ports target the same index, port 1 data is stored.
- Busy update for index i at each edge, in priority order:
  - rst → 0.
  - iss_valid and iss_rd=i → 1.
  - Any enabled write with waddr=i → 0.
  - Otherwise hold.
- Issue and writeback to the same index in the same cycle leave the bit set, because a new producer supersedes the old one.
- Issuing to a register that is already busy is legal; the bit stays set.
- Writing a register that is not busy is legal; the bit stays clear.
- Read, BYPASS=1:
  - rdataN = wdata1 if wen1 and waddr1=raddrN≠0.
  - Else wdata0 if wen0 and waddr0=raddrN≠0.
  - Else stored value.
  - rbusyN = stored busy bit, forced to 0 when a same-cycle enabled write hits raddrN.
  - Same-cycle issue does not affect rbusyN.
- Read, BYPASS=0: rdataN and rbusyN come from stored state only.
- busy_cnt is the popcount of the stored busy bits, registered so that it is consistent with the bits after each edge.
  - Range is 0..NREG-1.
  - Maintained as a counter: +1 per bit set, -1 per bit cleared, including the issue and write-clear to different indices in one cycle (net 0).
  - busy_cnt stays equal to the popcount.
- rst is held: writes and issues are ignored, and all state is cleared at every edge.

## Timing
- Reset values, valid after the first rst edge:
  - All data registers 0, all busy bits 0, busy_cnt 0.
  - rdata0/1 = 0 and rbusy0/1 = 0 for any index (when no bypass hits).
- Read path is combinational from raddr, stored state and, when BYPASS=1, the write ports. Latency 0.
- Write and issue latency: 1 cycle; visible in stored state after the next rising edge.
- rst asserted mid-operation: in-flight writes in that cycle are lost; the next cycle sees all-zero state.
- No handshake. Callers guarantee that a busy bit is never cleared by a stale writeback; this block performs no tag checking.

## Test plan
- Reset, then read all indices → rdata=0, rbusy=0, busy_cnt=0.
- wen0, waddr0=5, wdata0=0xDEAD_BEEF, raddr0=5 in the same cycle, BYPASS=1 → rdata0=0xDEAD_BEEF that cycle. With BYPASS=0 → 0 that cycle, 0xDEAD_BEEF next cycle.
- Both ports write index 7 (wdata0=0x11, wdata1=0x22) → stored and read value 0x22. Write 0x33 to index 0 → reads 0.
- Issue rd=3 → rbusy(3)=1 next cycle, busy_cnt=1. Write back index 3 with iss_rd=3 in the same cycle → bit stays 1. Write back alone → 0, busy_cnt=0.
- Issue rd=4 and write back rd=9 (busy) in the same cycle → busy_cnt unchanged, bit 4=1, bit 9=0. Issue rd=0 → busy_cnt unchanged.
- Fill registers 1..31 busy via issues → busy_cnt=31. Assert rst for one cycle mid-stream with concurrent writes → all data 0, busy_cnt=0, writes dropped.
